tl_response_serializer: RTL

//  Next-generation TileLink-to-UART response path. Accepts TileLink frames from the

---
 rtl/tl_response_serializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tl_response_serializer.sv
// Purpose: buffers TileLink response frames in a FIFO_DEPTH-deep packet FIFO and streams each one as bytes to a UART transmitter.
// Latency: the first byte is valid the cycle after the frame push edge, and back-to-back packets stream with no bubble.
// Backpressure: tl_out_ready drops while FIFO_DEPTH frames are held, and tx_valid/tx_data hold steady while tx_ready is low.
//
// Optional feature: define TL_RESP_CHECKSUM_EN to append an XOR checksum byte to every packet.
//
// Ports:
//   clk, reset (async, active-high)
//   tl_out_valid/tl_out_ready : frame handshake from the deserializer
//   tl_out_bits_*             : frame fields (source is not transmitted)
//   tx_valid/tx_ready/tx_data : byte stream toward the UART
//   fifo_count                : frames held, including the one being sent
//   trunc_err                 : sticky flag, set when a field bit that does not fit the packet was nonzero
module tl_response_serializer #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tl_out_valid,
    output logic                          tl_out_ready,
    input  logic [2:0]                    tl_out_bits_chanId,
    input  logic [2:0]                    tl_out_bits_opcode,
    input  logic [2:0]                    tl_out_bits_param,
    input  logic [7:0]                    tl_out_bits_size,
    input  logic [7:0]                    tl_out_bits_source,
    input  logic [63:0]                   tl_out_bits_address,
    input  logic [63:0]                   tl_out_bits_data,
    input  logic                          tl_out_bits_corrupt,
    input  logic [8:0]                    tl_out_bits_union,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [7:0]                    tx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          trunc_err
);

    localparam int PKT_BYTES = 4 + ADDR_BYTES + DATA_BYTES;
`ifdef TL_RESP_CHECKSUM_EN
    localparam int PKT_LEN   = PKT_BYTES + 1;
`else
    localparam int PKT_LEN   = PKT_BYTES;
`endif
    localparam int PKT_W = 8 * PKT_LEN;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int IW    = $clog2(PKT_LEN);

    // Bits of address/data that fit into the packet; anything outside is dropped.
    localparam logic [63:0] ADDR_MASK = (ADDR_BYTES >= 8) ? '1 : ((64'd1 << (8 * ADDR_BYTES)) - 64'd1);
    localparam logic [63:0] DATA_MASK = (DATA_BYTES >= 8) ? '1 : ((64'd1 << (8 * DATA_BYTES)) - 64'd1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nxt;
    logic [PKT_W-1:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [IW-1:0]          idx, idx_nxt;
    logic [CW-1:0]          count_nxt;
    logic [8*PKT_BYTES-1:0] body;
    logic [PKT_W-1:0]       pkt_in;
    logic [PKT_W-1:0]       pkt_head;
    logic [7:0]             cur_byte;
    logic                   full, push, pop, tx_fire, last_byte, frame_trunc;

    // Source id is accepted but never transmitted.
    logic unused_source;
    assign unused_source = ^tl_out_bits_source;

    // Byte i of the packet lives at body[8*i +: 8], so b0 is in the low byte.
    assign body = {tl_out_bits_data[8*DATA_BYTES-1:0],
                   tl_out_bits_address[8*ADDR_BYTES-1:0],
                   tl_out_bits_union[7:0],
                   tl_out_bits_size,
                   {tl_out_bits_corrupt, tl_out_bits_param, 1'b0, tl_out_bits_opcode},
                   {5'b00000, tl_out_bits_chanId}};

`ifdef TL_RESP_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < PKT_BYTES; i++) begin
            csum = csum ^ body[8*i +: 8];
        end
    end
    assign pkt_in = {csum, body};
`else
    assign pkt_in = body;
`endif

    assign frame_trunc = tl_out_bits_union[8]
                       | (|(tl_out_bits_address & ~ADDR_MASK))
                       | (|(tl_out_bits_data    & ~DATA_MASK));

    // FIFO control. Pushing is blocked while full even if the head pops in the same cycle.
    assign full         = (fifo_count == CW'(FIFO_DEPTH));
    assign tl_out_ready = !full && !reset;
    assign push         = tl_out_valid && tl_out_ready;

    assign tx_valid  = (state == SEND);
    assign tx_fire   = tx_valid && tx_ready;
    assign last_byte = (idx == IW'(PKT_LEN - 1));
    assign pop       = tx_fire && last_byte;
    assign count_nxt = fifo_count + CW'(push) - CW'(pop);

    assign pkt_head = mem[rd_ptr];
    assign cur_byte = pkt_head[{idx, 3'b000} +: 8];
    assign tx_data  = tx_valid ? cur_byte : 8'h00;

    // A push moves IDLE straight to SEND, so the first byte is presented right after the push edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (push || (fifo_count != '0)) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (tx_fire) begin
                    if (last_byte) begin
                        idx_nxt = '0;
                        if (count_nxt == '0) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            trunc_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            fifo_count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && frame_trunc) begin
                trunc_err <= 1'b1;
            end
        end
    end

    // Packet storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

endmodule
